seg_capture_decoder: RTL and testbench
======================================

Name: seg_capture_decoder

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoder: samples a multiplexed, active-high 7-segment bus (`seg_in` plus one-hot digit enables) and recovers the hex nibble shown on each digit.
- Qualifies each pattern by stability, decodes it, and keeps a per-digit register file with valid flags.
- Sits in the bench/monitor path and in loopback self-test beside the display driver.

Parameters:
- `NDIG`, 4, number of multiplexed digits; legal range ≥ 1.
- `STABLE_CYCLES`, 4, consecutive identical samples required before capture; legal range ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `seg_in` in 7: segments a..g, active high; bit 6 = a, bit 0 = g.
- `dig_en` in `NDIG`: digit select, active high; bit i selects digit i.
- `clear` in 1: synchronous; clears all `digit_valid` bits.
- `value` out 4*`NDIG`: decoded nibbles; digit i occupies bits [4i+3:4i].
- `digit_valid` out `NDIG`: bit i is 1 when `value` slot i holds a legally decoded pattern.
- `upd` out 1: one-cycle pulse; a legal capture occurred.
- `upd_idx` out max(1, $clog2(`NDIG`)): binary index of the digit captured by `upd` or `bad_pattern`.
- `bad_pattern` out 1: one-cycle pulse; a stable pattern was not in the decode table.

Behaviour:
- Reset (async assert, released on a clk edge internally):
  - `value` = 0, `digit_valid` = 0, `upd` = 0, `upd_idx` = 0, `bad_pattern` = 0.
  - Run counter = 0; previous-sample register = 0.
- Sample definition: the pair (`dig_en`, `seg_in`) taken at each rising edge. A sample is "active" iff `dig_en` is exactly one-hot.
- Run tracking:
  - Active sample identical to the previous sample: run count increments, saturating at `STABLE_CYCLES`.
  - Active sample that differs: run count restarts at 1.
  - Inactive sample (zero or multi-hot `dig_en`, i.e. blanking or a transition glitch): run count goes to 0; no flags raised.
- Capture:
  - Occurs exactly once per run, on the edge where run count reaches `STABLE_CYCLES`.
  - With `STABLE_CYCLES` = 1, capture occurs on the first active sample of each new run.
  - Outputs are registered: a capture on edge N is visible after edge N.
  - Latency: a pattern first sampled on edge k is reflected after edge k+`STABLE_CYCLES`-1.
  - Holding the pattern longer produces no further captures. `dig_en` must change, or an inactive sample must occur, to re-arm.
- Decode table (`seg_in` hex → nibble):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7
  - 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F
  - All other patterns, including 00, are illegal.
- Legal capture on digit i:
  - `value` slot i ← nibble; `digit_valid`[i] ← 1.
  - `upd` = 1 and `upd_idx` = i for one cycle.
- Illegal capture on digit i:
  - `value` slot i unchanged; `digit_valid`[i] ← 0.
  - `bad_pattern` = 1 and `upd_idx` = i for one cycle; `upd` stays 0.
- `clear`:
  - Clears all `digit_valid` bits on that edge; `value` is unchanged; the run counter is unaffected.
  - If `clear` and a capture coincide, the capture's slot result wins; all other slots clear.
- Pulse outputs: `upd` and `bad_pattern` are 0 on every edge without a capture. `upd_idx` holds its last value between pulses.
- Reset mid-run: all state is lost; a pattern held across reset release needs a full `STABLE_CYCLES` run after release.

Test Plan:
1. Legal capture, exact latency. Reset; drive `dig_en`=0001, `seg_in`=7'h6D for 4 edges.
   - Required: after the 4th edge, `value`[3:0]=2, `digit_valid`=0001, `upd`=1 for 1 cycle, `upd_idx`=0.
   - Required: holding 10 more edges gives no further `upd`.
2. Short run rejected. `dig_en`=0100 with `seg_in`=7'h77 for 3 edges, then `dig_en`=0000.
   - Required: no `upd`; `digit_valid`[2]=0.
   - Then 4 edges of the same pattern → `value`[11:8]=A, `upd_idx`=2.
3. Full table sweep. Step all 16 legal patterns on digit 3, each held 4 edges with a 1-edge blank between.
   - Required: `value`[15:12] follows 0..F; exactly 16 `upd` pulses; no `bad_pattern`.
4. Illegal pattern. Digit 1 already holds 5; drive `seg_in`=7'h00 on `dig_en`=0010 for 4 edges.
   - Required: `bad_pattern` pulse, `upd_idx`=1, `digit_valid`[1]=0, `value`[7:4] still 5.
5. Multi-hot and `clear`/capture collision.
   - `dig_en`=0011 for 8 edges → no `upd`, no `bad_pattern`.
   - Then assert `clear` on the same edge as a legal capture to digit 0 while digit 2 is valid → after the edge, `digit_valid`=0001.
6. Asynchronous reset mid-run. Assert `rst_n`=0 between edges after 2 edges of a stable pattern.
   - Required: all outputs go to 0 immediately, without waiting for a clock edge.
   - Required: after release, capture only after 4 further edges of the held pattern.

Source files
------------

// File: rtl/seg_capture_decoder.sv
// Recovers hex nibbles from a multiplexed active-high 7-segment bus.
// Each one-hot digit pattern must hold STABLE_CYCLES samples before it is decoded into the register file.
module seg_capture_decoder #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IW           = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_en,
    input  logic              clear,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_valid,
    output logic              upd,
    output logic [IW-1:0]     upd_idx,
    output logic              bad_pattern
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
    localparam logic [RW-1:0] RUN_PRE = RW'(STABLE_CYCLES - 1);

    // Returns {legal, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h7E:   r = {1'b1, 4'h0};
            7'h30:   r = {1'b1, 4'h1};
            7'h6D:   r = {1'b1, 4'h2};
            7'h79:   r = {1'b1, 4'h3};
            7'h33:   r = {1'b1, 4'h4};
            7'h5B:   r = {1'b1, 4'h5};
            7'h5F:   r = {1'b1, 4'h6};
            7'h70:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h7B:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h1F:   r = {1'b1, 4'hB};
            7'h4E:   r = {1'b1, 4'hC};
            7'h3D:   r = {1'b1, 4'hD};
            7'h4F:   r = {1'b1, 4'hE};
            7'h47:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [NDIG-1:0]   prev_en_q, prev_en_d;
    logic [6:0]        prev_seg_q, prev_seg_d;
    logic [RW-1:0]     run_q, run_d;
    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              upd_q, upd_d;
    logic              bad_q, bad_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic              active;
    logic              same;
    logic              capture;
    logic [4:0]        dec;
    logic [IW-1:0]     sel_idx;

    always_comb begin
        active     = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
        same       = (dig_en == prev_en_q) && (seg_in == prev_seg_q);
        dec        = decode_seg(seg_in);
        prev_en_d  = dig_en;
        prev_seg_d = seg_in;

        sel_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_en[i]) sel_idx = IW'(i);
        end

        // A repeat of a saturated run must not re-capture; a fresh run captures at once only when STABLE_CYCLES is 1.
        if (!active) begin
            run_d   = '0;
            capture = 1'b0;
        end else if (same) begin
            run_d   = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
            capture = (run_q == RUN_PRE);
        end else begin
            run_d   = RW'(1);
            capture = (STABLE_CYCLES == 1);
        end

        value_d = value_q;
        valid_d = clear ? '0 : valid_q;
        upd_d   = 1'b0;
        bad_d   = 1'b0;
        idx_d   = idx_q;

        if (capture) begin
            idx_d = sel_idx;
            upd_d = dec[4];
            bad_d = ~dec[4];
            for (int i = 0; i < NDIG; i++) begin
                if (dig_en[i]) begin
                    valid_d[i] = dec[4];
                    if (dec[4]) value_d[4*i +: 4] = dec[3:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_en_q  <= '0;
            prev_seg_q <= '0;
            run_q      <= '0;
            value_q    <= '0;
            valid_q    <= '0;
            upd_q      <= 1'b0;
            bad_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            prev_en_q  <= prev_en_d;
            prev_seg_q <= prev_seg_d;
            run_q      <= run_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            upd_q      <= upd_d;
            bad_q      <= bad_d;
            idx_q      <= idx_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign upd         = upd_q;
    assign upd_idx     = idx_q;
    assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Bench for seg_capture_decoder: directed scenarios plus a randomized run against a sample-history model.
module tb_seg_capture_decoder;

    localparam int NDIG = 4;
    localparam int S    = 4;
    localparam int IW   = 2;
    localparam int BW   = 4*NDIG + NDIG + 1 + IW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg_in = '0;
    logic [NDIG-1:0]   dig_en = '0;
    logic              clear = 1'b0;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   digit_valid;
    logic              upd;
    logic [IW-1:0]     upd_idx;
    logic              bad_pattern;

    seg_capture_decoder #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en), .clear(clear),
        .value(value), .digit_valid(digit_valid), .upd(upd), .upd_idx(upd_idx),
        .bad_pattern(bad_pattern)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: remembers the last sample and how many times in a row it has been seen.
    logic [4*NDIG-1:0] m_value;
    logic [NDIG-1:0]   m_valid;
    logic              m_upd, m_bad;
    logic [IW-1:0]     m_idx;
    logic [NDIG-1:0]   m_prev_en;
    logic [6:0]        m_prev_seg;
    int                m_count;

    wire [BW-1:0] obs = {value, digit_valid, upd, upd_idx, bad_pattern};
    wire [BW-1:0] exp_b = {m_value, m_valid, m_upd, m_idx, m_bad};

    function automatic void model_reset();
        m_value = '0; m_valid = '0; m_upd = 0; m_bad = 0; m_idx = '0;
        m_prev_en = '0; m_prev_seg = '0; m_count = 0;
    endfunction

    function automatic void model_edge(input logic [NDIG-1:0] en, input logic [6:0] seg,
                                       input logic clr);
        bit active = ($countones(en) == 1);
        int pos = 0;
        int nib = -1;
        if (!active) m_count = 0;
        else if (en == m_prev_en && seg == m_prev_seg) m_count++;
        else m_count = 1;
        m_prev_en = en;
        m_prev_seg = seg;
        m_upd = 0;
        m_bad = 0;
        if (clr) m_valid = '0;
        if (active && m_count == S) begin
            for (int i = 0; i < NDIG; i++) if (en[i]) pos = i;
            for (int k = 0; k < 16; k++) if (tbl[k] == seg) nib = k;
            m_idx = IW'(pos);
            if (nib >= 0) begin
                m_value[4*pos +: 4] = 4'(nib);
                m_valid[pos] = 1'b1;
                m_upd = 1;
            end else begin
                m_valid[pos] = 1'b0;
                m_bad = 1;
            end
        end
    endfunction

    task automatic step(input logic [NDIG-1:0] en, input logic [6:0] seg, input logic clr);
        dig_en = en; seg_in = seg; clear = clr;
        @(posedge clk);
        model_edge(en, seg, clr);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; dig_en = '0; seg_in = '0; clear = 0;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 1;
        #2 rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        @(posedge clk);
        #3 rst_n = 1;
    endtask

    task automatic test_latency();
        int pulses = 0;
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            step(4'b0001, 7'h6D, 0);
            n_cmp++;
            if (upd !== (e == 4)) begin
                n_bad++;
                $display("FAIL latency_upd edge%0d: got %b want %b", e, upd, (e == 4));
            end
        end
        n_cmp++;
        if (value[3:0] !== 4'h2 || digit_valid !== 4'b0001 || upd_idx !== 0 || obs !== exp_b) begin
            n_bad++;
            $display("FAIL latency_capture: got %h want %h", obs, exp_b);
        end
        for (int e = 0; e < 10; e++) begin
            step(4'b0001, 7'h6D, 0);
            if (upd) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL hold_no_recapture: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_short_run();
        int pulses = 0;
        for (int e = 0; e < 3; e++) begin
            step(4'b0100, 7'h77, 0);
            if (upd) pulses++;
        end
        step(4'b0000, 7'h77, 0);
        n_cmp++;
        if (pulses !== 0 || digit_valid[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL short_run: got pulses %0d valid2 %b want 0 0", pulses, digit_valid[2]);
        end
        for (int e = 0; e < 4; e++) step(4'b0100, 7'h77, 0);
        n_cmp++;
        if (value[11:8] !== 4'hA || upd_idx !== 2 || upd !== 1'b1) begin
            n_bad++;
            $display("FAIL short_run_recapture: got val %h idx %0d upd %b want A 2 1",
                     value[11:8], upd_idx, upd);
        end
    endtask

    task automatic test_sweep();
        int ups = 0, bads = 0, seq_err = 0;
        for (int n = 0; n < 16; n++) begin
            for (int e = 0; e < 4; e++) begin
                step(4'b1000, tbl[n], 0);
                if (upd) ups++;
                if (bad_pattern) bads++;
            end
            if (value[15:12] !== 4'(n) || obs !== exp_b) seq_err++;
            step(4'b0000, 7'h00, 0);
        end
        n_cmp++;
        if (ups !== 16 || bads !== 0 || seq_err !== 0) begin
            n_bad++;
            $display("FAIL table_sweep: got upd %0d bad %0d seqerr %0d want 16 0 0",
                     ups, bads, seq_err);
        end
    endtask

    task automatic test_illegal();
        for (int e = 0; e < 4; e++) step(4'b0010, 7'h5B, 0);
        step(4'b0000, 7'h00, 0);
        for (int e = 0; e < 4; e++) step(4'b0010, 7'h00, 0);
        n_cmp++;
        if (bad_pattern !== 1'b1 || upd !== 1'b0 || upd_idx !== 1 ||
            digit_valid[1] !== 1'b0 || value[7:4] !== 4'h5) begin
            n_bad++;
            $display("FAIL illegal: got bad %b upd %b idx %0d v1 %b val %h want 1 0 1 0 5",
                     bad_pattern, upd, upd_idx, digit_valid[1], value[7:4]);
        end
    endtask

    task automatic test_multihot_clear();
        int flags = 0;
        for (int e = 0; e < 8; e++) begin
            step(4'b0011, 7'h30, 0);
            if (upd || bad_pattern) flags++;
        end
        n_cmp++;
        if (flags !== 0) begin
            n_bad++;
            $display("FAIL multihot: got %0d flags want 0", flags);
        end
        for (int e = 0; e < 4; e++) step(4'b0100, 7'h30, 0);
        step(4'b0000, 7'h00, 0);
        for (int e = 0; e < 3; e++) step(4'b0001, 7'h7E, 0);
        n_cmp++;
        if (digit_valid[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_setup: got valid %b want bit2 set", digit_valid);
        end
        step(4'b0001, 7'h7E, 1);
        n_cmp++;
        if (digit_valid !== 4'b0001 || value[3:0] !== 4'h0 || upd !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_collision: got valid %b upd %b want 0001 1", digit_valid, upd);
        end
    endtask

    task automatic test_async_reset();
        for (int e = 0; e < 4; e++) step(4'b0001, 7'h79, 0);
        step(4'b0000, 7'h00, 0);
        step(4'b0010, 7'h33, 0);
        step(4'b0010, 7'h33, 0);
        #2 rst_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", obs);
        end
        #2 rst_n = 1;
        for (int e = 1; e <= 4; e++) begin
            step(4'b0010, 7'h33, 0);
            n_cmp++;
            if (upd !== (e == 4) || obs !== exp_b) begin
                n_bad++;
                $display("FAIL post_reset edge%0d: got %h want %h", e, obs, exp_b);
            end
        end
    endtask

    task automatic test_random();
        logic [NDIG-1:0] en = '0;
        logic [6:0] seg = '0;
        logic [NDIG-1:0] multi [7] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'hF};
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 9) < 3) begin
                int r = $urandom_range(0, 9);
                if (r < 7) en = NDIG'(1 << $urandom_range(0, NDIG - 1));
                else if (r == 7) en = '0;
                else en = multi[$urandom_range(0, 6)];
                seg = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
            end
            step(en, seg, ($urandom_range(0, 19) == 0));
            n_cmp++;
            if (obs !== exp_b) begin
                n_bad++;
                $display("FAIL random t%0d: got %h want %h", t, obs, exp_b);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_short_run();
        test_sweep();
        test_illegal();
        test_multihot_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
